// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame-sequencer state
// encoding and line-mux select codes.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] MUX_IDLE  = 2'd0;
    localparam logic [1:0] MUX_START = 2'd1;
    localparam logic [1:0] MUX_DATA  = 2'd2;
    localparam logic [1:0] MUX_PAR   = 2'd3;

endpackage

// File: rtl/uart_tx_controller_parity_calc.sv
// Combinational parity generator: even parity when par_typ=0, odd when 1.
// Kept standalone so the receiver can reuse it for checking.
module parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  par_typ,
    output logic                  parity_bit
);

    // Seeding the XOR chain with par_typ turns even parity into odd parity.
    logic [DATA_WIDTH:0] chain;

    assign chain[0] = par_typ;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_xor
            assign chain[gi+1] = chain[gi] ^ data_in[gi];
        end
    endgenerate

    assign parity_bit = chain[DATA_WIDTH];

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: one-entry holding register with valid/ready
// intake, then start / data / parity / stop sequencing at one bit per baud clock.
module uart_tx_controller
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int TIMEOUT    = DATA_WIDTH + 2
) (
    input  logic                  TxCtrl_CLK,
    input  logic                  TxCtrl_RST_ASYN,
    input  logic [DATA_WIDTH-1:0] TxCtrl_DataIn,
    input  logic                  TxCtrl_DataValid,
    output logic                  TxCtrl_DataReady,
    input  logic                  TxCtrl_ParEn,
    input  logic                  TxCtrl_ParTyp,
    output logic [DATA_WIDTH-1:0] TxCtrl_SerData,
    output logic                  TxCtrl_SerLoad,
    output logic                  TxCtrl_SerEn,
    input  logic                  TxCtrl_SerDone,
    output logic [1:0]            TxCtrl_MuxSel,
    output logic                  TxCtrl_ParityBit,
    output logic                  TxCtrl_Busy,
    output logic                  TxCtrl_FrameErr
);

    // One counter serves both the DATA timeout and the STOP-bit count.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_paren_q, hold_paren_d;
    logic                  hold_par_q, hold_par_d;
    logic                  frame_paren_q, frame_paren_d;
    logic                  frame_par_q, frame_par_d;
    logic                  ready_q, ready_d;
    logic                  par_calc;
    logic                  accept;
    logic                  frame_err;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_in    (TxCtrl_DataIn),
        .par_typ    (TxCtrl_ParTyp),
        .parity_bit (par_calc)
    );

    assign accept = TxCtrl_DataValid && ready_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hold_full_d   = hold_full_q;
        hold_data_d   = hold_data_q;
        hold_paren_d  = hold_paren_q;
        hold_par_d    = hold_par_q;
        frame_paren_d = frame_paren_q;
        frame_par_d   = frame_par_q;
        frame_err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = START;
                end
            end
            START: begin
                hold_full_d   = 1'b0;
                frame_paren_d = hold_paren_q;
                frame_par_d   = hold_par_q;
                cnt_d         = '0;
                state_d       = DATA;
            end
            DATA: begin
                // Done takes priority over a coincident timeout.
                if (TxCtrl_SerDone) begin
                    cnt_d   = '0;
                    state_d = frame_paren_q ? PARITY : STOP;
                end else if (cnt_q == TO_LAST) begin
                    frame_err = 1'b1;
                    cnt_d     = '0;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PARITY: begin
                cnt_d   = '0;
                state_d = STOP;
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = hold_full_q ? START : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            hold_full_d  = 1'b1;
            hold_data_d  = TxCtrl_DataIn;
            hold_paren_d = TxCtrl_ParEn;
            hold_par_d   = par_calc;
        end

        ready_d = !hold_full_d;
    end

    always_ff @(posedge TxCtrl_CLK or negedge TxCtrl_RST_ASYN) begin
        if (!TxCtrl_RST_ASYN) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hold_full_q   <= 1'b0;
            hold_data_q   <= '0;
            hold_paren_q  <= 1'b0;
            hold_par_q    <= 1'b0;
            frame_paren_q <= 1'b0;
            frame_par_q   <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_full_q   <= hold_full_d;
            hold_data_q   <= hold_data_d;
            hold_paren_q  <= hold_paren_d;
            hold_par_q    <= hold_par_d;
            frame_paren_q <= frame_paren_d;
            frame_par_q   <= frame_par_d;
            ready_q       <= ready_d;
        end
    end

    always_comb begin
        TxCtrl_MuxSel  = MUX_IDLE;
        TxCtrl_SerLoad = 1'b0;
        TxCtrl_SerEn   = 1'b0;
        TxCtrl_SerData = '0;
        TxCtrl_Busy    = (state_q != IDLE);
        case (state_q)
            START: begin
                TxCtrl_MuxSel  = MUX_START;
                TxCtrl_SerLoad = 1'b1;
                TxCtrl_SerData = hold_data_q;
            end
            DATA: begin
                TxCtrl_MuxSel = MUX_DATA;
                TxCtrl_SerEn  = 1'b1;
            end
            PARITY: TxCtrl_MuxSel = MUX_PAR;
            default: TxCtrl_MuxSel = MUX_IDLE;
        endcase
    end

    assign TxCtrl_DataReady = ready_q;
    assign TxCtrl_ParityBit = frame_par_q;
    assign TxCtrl_FrameErr  = frame_err;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Cycle-accurate directed bench for uart_tx_controller: a per-cycle trace table
// plus hand-written timeout and mid-frame reset sequences.
module tb_uart_tx_controller;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       par_en;
    logic       par_typ;
    logic [7:0] ser_data;
    logic       ser_load;
    logic       ser_en;
    logic       ser_done;
    logic [1:0] mux_sel;
    logic       parity_bit;
    logic       busy;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_controller #(
        .DATA_WIDTH (8),
        .STOP_BITS  (1)
    ) dut (
        .TxCtrl_CLK       (clk),
        .TxCtrl_RST_ASYN  (rst_n),
        .TxCtrl_DataIn    (data_in),
        .TxCtrl_DataValid (valid),
        .TxCtrl_DataReady (ready),
        .TxCtrl_ParEn     (par_en),
        .TxCtrl_ParTyp    (par_typ),
        .TxCtrl_SerData   (ser_data),
        .TxCtrl_SerLoad   (ser_load),
        .TxCtrl_SerEn     (ser_en),
        .TxCtrl_SerDone   (ser_done),
        .TxCtrl_MuxSel    (mux_sel),
        .TxCtrl_ParityBit (parity_bit),
        .TxCtrl_Busy      (busy),
        .TxCtrl_FrameErr  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] din;
        logic       pe;
        logic       pt;
        logic       dn;
        logic       e_rdy;
        logic [1:0] e_mux;
        logic       e_ld;
        logic       e_en;
        logic       e_busy;
        logic       e_par;
        logic       e_err;
        logic [7:0] e_sd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] din, input logic pe,
                       input logic pt, input logic dn, input logic rdy,
                       input logic [1:0] mux, input logic ld, input logic en,
                       input logic bsy, input logic par, input logic err,
                       input logic [7:0] sd);
        vec_t r;
        r.v = v; r.din = din; r.pe = pe; r.pt = pt; r.dn = dn;
        r.e_rdy = rdy; r.e_mux = mux; r.e_ld = ld; r.e_en = en;
        r.e_busy = bsy; r.e_par = par; r.e_err = err; r.e_sd = sd;
        vecs.push_back(r);
    endtask

    task automatic chk(input string tag, input string fld,
                       input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rdy, input logic [1:0] mux,
                             input logic ld, input logic en, input logic bsy,
                             input logic par, input logic err, input logic [7:0] sd);
        chk(tag, "ready",  {7'd0, ready},      {7'd0, rdy});
        chk(tag, "mux",    {6'd0, mux_sel},    {6'd0, mux});
        chk(tag, "load",   {7'd0, ser_load},   {7'd0, ld});
        chk(tag, "en",     {7'd0, ser_en},     {7'd0, en});
        chk(tag, "busy",   {7'd0, busy},       {7'd0, bsy});
        chk(tag, "parity", {7'd0, parity_bit}, {7'd0, par});
        chk(tag, "err",    {7'd0, frame_err},  {7'd0, err});
        chk(tag, "sdata",  ser_data,           sd);
    endtask

    // Drive one cycle of inputs after the falling edge and settle before sampling.
    task automatic cyc(input logic v, input logic [7:0] din, input logic pe,
                       input logic pt, input logic dn);
        @(negedge clk);
        valid = v; data_in = din; par_en = pe; par_typ = pt; ser_done = dn;
        #1;
    endtask

    task automatic run_table(input string pass);
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].v, vecs[i].din, vecs[i].pe, vecs[i].pt, vecs[i].dn);
            check_out($sformatf("%s_row%0d", pass, i), vecs[i].e_rdy, vecs[i].e_mux,
                      vecs[i].e_ld, vecs[i].e_en, vecs[i].e_busy, vecs[i].e_par,
                      vecs[i].e_err, vecs[i].e_sd);
            $display("%s row %0d: v=%0d din=%h done=%0d mux=%0d busy=%0d par=%0d rdy=%0d",
                     pass, i, vecs[i].v, vecs[i].din, vecs[i].dn, mux_sel, busy,
                     parity_bit, ready);
        end
    endtask

    // One frame of 0x00, even parity enabled, Done optionally raised on DATA cycle 9.
    task automatic timeout_frame(input string tag, input logic done_late,
                                 input logic par_before);
        cyc(1, 8'h00, 1, 0, 0);
        check_out({tag, "_acc"}, 1, 0, 0, 0, 0, par_before, 0, 8'h00);
        cyc(0, 8'h00, 0, 0, 0);
        check_out({tag, "_idle"}, 0, 0, 0, 0, 0, par_before, 0, 8'h00);
        cyc(0, 8'h00, 0, 0, 0);
        check_out({tag, "_start"}, 0, 1, 1, 0, 1, par_before, 0, 8'h00);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 8'h00, 0, 0, (k == 9) && done_late);
            check_out($sformatf("%s_data%0d", tag, k), 1, 2, 0, 1, 1, 0,
                      (k == 9) && !done_late, 8'h00);
        end
        if (done_late) begin
            cyc(0, 8'h00, 0, 0, 0);
            check_out({tag, "_parity"}, 1, 3, 0, 0, 1, 0, 0, 8'h00);
        end
        cyc(0, 8'h00, 0, 0, 0);
        check_out({tag, "_stop"}, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        cyc(0, 8'h00, 0, 0, 0);
        check_out({tag, "_end"}, 1, 0, 0, 0, 0, 0, 0, 8'h00);
        $display("%s: frame of 0x00 with done_late=%0d complete", tag, done_late);
    endtask

    initial begin
        // 8E1 0xD6, with 0xA5 (no parity) accepted in the first DATA cycle
        add(1, 8'hD6, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 1, 1, 0, 1, 0, 0, 8'hD6);
        add(1, 8'hA5, 0, 0, 0,  1, 2, 0, 1, 1, 1, 0, 8'h00);
        add(1, 8'hA5, 0, 0, 0,  0, 2, 0, 1, 1, 1, 0, 8'h00);
        for (int k = 2; k < 8; k++)
            add(0, 8'h00, 0, 0, (k == 7), 0, 2, 0, 1, 1, 1, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 3, 0, 0, 1, 1, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 1, 1, 0, 1, 1, 0, 8'hA5);
        for (int k = 0; k < 8; k++)
            add(0, 8'h00, 0, 0, (k == 7), 1, 2, 0, 1, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 8'h00);
        // 8O1 0xD6: odd parity of five ones is 0
        add(1, 8'hD6, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 1, 1, 0, 1, 0, 0, 8'hD6);
        for (int k = 0; k < 8; k++)
            add(0, 8'h00, 0, 0, (k == 7), 1, 2, 0, 1, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  1, 3, 0, 0, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 8'h00);
        // 8N1 0xD6, then 0xA5 odd accepted in the last STOP cycle
        add(1, 8'hD6, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 1, 1, 0, 1, 0, 0, 8'hD6);
        for (int k = 0; k < 8; k++)
            add(0, 8'h00, 0, 0, (k == 7), 1, 2, 0, 1, 1, 1, 0, 8'h00);
        add(1, 8'hA5, 1, 1, 0,  1, 0, 0, 0, 1, 1, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  0, 1, 1, 0, 1, 1, 0, 8'hA5);
        for (int k = 0; k < 8; k++)
            add(0, 8'h00, 0, 0, (k == 7), 1, 2, 0, 1, 1, 1, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  1, 3, 0, 0, 1, 1, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 1, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 8'h00);

        rst_n = 1'b0; valid = 1'b0; data_in = 8'h00;
        par_en = 1'b0; par_typ = 1'b0; ser_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_out("reset", 1, 0, 0, 0, 0, 0, 0, 8'h00);
        $display("reset: mux=%0d ready=%0d busy=%0d", mux_sel, ready, busy);
        @(negedge clk);
        rst_n = 1'b1;

        run_table("t1");

        timeout_frame("tmo", 1'b0, 1'b1);
        timeout_frame("done_vs_tmo", 1'b1, 1'b0);

        run_table("t2");

        // Reset in the middle of DATA with a second byte waiting in the holding register
        cyc(1, 8'hD6, 1, 0, 0);
        check_out("rst_acc", 1, 0, 0, 0, 0, 1, 0, 8'h00);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        check_out("rst_start", 0, 1, 1, 0, 1, 1, 0, 8'hD6);
        cyc(1, 8'hA5, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        check_out("rst_data1", 0, 2, 0, 1, 1, 1, 0, 8'h00);
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 1, 0, 0, 0, 0, 0, 0, 8'h00);
        $display("reset mid-DATA: mux=%0d ready=%0d busy=%0d", mux_sel, ready, busy);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 8'h00, 0, 0, 0);
            check_out($sformatf("rst_after%0d", k), 1, 0, 0, 0, 0, 0, 0, 8'h00);
            $display("post-reset cycle %0d: mux=%0d busy=%0d", k, mux_sel, busy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
Frame sequencer for the UART transmitter. Accepts a parallel byte through a valid/ready handshake into a one-entry holding register and computes its parity. Loads and enables the Seralizer, and steps the output mux through start, data, parity and stop bits. Runs on the baud-rate clock, one bit per clock, and supports back-to-back frames with no idle gap.

Parameters:
DATA_WIDTH, 8, payload bits per frame; also width of the Seralizer parallel input.
STOP_BITS, 1, number of stop-bit cycles per frame (1 or 2).
TIMEOUT, DATA_WIDTH+2, DATA-state cycle limit before Ser_Done is declared missing.

Ports:
TxCtrl_CLK  in  1  baud clock (9.6 kHz); all state on the rising edge.
TxCtrl_RST_ASYN  in  1  asynchronous reset, active-low.
TxCtrl_DataIn  in  DATA_WIDTH  byte to transmit.
TxCtrl_DataValid  in  1  byte offered this cycle.
TxCtrl_DataReady  out  1  holding register empty; byte accepted when Valid&&Ready.
TxCtrl_ParEn  in  1  parity bit enabled; sampled at acceptance.
TxCtrl_ParTyp  in  1  0 = even, 1 = odd; sampled at acceptance.
TxCtrl_SerData  out  DATA_WIDTH  byte presented to Seralizer_ParallelData.
TxCtrl_SerLoad  out  1  load strobe to the Seralizer.
TxCtrl_SerEn  out  1  drives Seralizer_En.
TxCtrl_SerDone  in  1  from Seralizer_done.
TxCtrl_MuxSel  out  2  line mux: 0 = idle/stop (1), 1 = start (0), 2 = serial data, 3 = parity.
TxCtrl_ParityBit  out  1  parity bit for the current frame.
TxCtrl_Busy  out  1  frame in progress (state != IDLE).
TxCtrl_FrameErr  out  1  one-cycle pulse on Ser_Done timeout.

Behaviour:
- Reset (async, low): state = IDLE and holding register empty. Outputs: DataReady=1, SerData=0, SerLoad=0, SerEn=0, MuxSel=0, ParityBit=0, Busy=0, FrameErr=0.
- Acceptance: on an edge with Valid&&Ready, latch DataIn, ParEn and ParTyp, plus parity (even: ^DataIn; odd: ~^DataIn) into the holding register. hold_full<=1.
- DataReady = !hold_full, registered. There is no same-cycle bypass, so Valid offered while the register is being freed waits one cycle.
- All outputs except DataReady and FrameErr are a Moore decode of state and latched frame registers.
- IDLE: MuxSel=0, Busy=0. If hold_full → START on the next edge.
- START (1 cycle): MuxSel=1, SerLoad=1, SerData=held byte, ParityBit/ParEn copied to frame registers. hold_full<=0 at the end of START → DATA.
- DATA: MuxSel=2, SerEn=1, cycle counter increments each cycle from 0.
  - Ser_Done=1 sampled → PARITY if frame ParEn, else STOP.
  - Counter reaches TIMEOUT-1 without Done → FrameErr pulse for 1 cycle, then STOP (frame abandoned, line driven high).
- PARITY (1 cycle): MuxSel=3 → STOP.
- STOP (STOP_BITS cycles): MuxSel=0. On the last cycle: hold_full → START (back-to-back), else IDLE.
- Nominal frame length = 1 + DATA_WIDTH + ParEn + STOP_BITS cycles (11 for 8E1).
- Simultaneous events:
  - Valid arriving during the last STOP cycle with Ready=1 is accepted but starts after one IDLE cycle.
  - Done and timeout on the same cycle: Done wins, no error.
- Config changes on ParEn/ParTyp mid-frame have no effect on the current frame.
- Reset mid-frame: immediate return to IDLE. The holding-register byte is discarded and the line returns to idle high.

Decomposition:
- Package uart_tx_pkg: state encoding (IDLE, START, DATA, PARITY, STOP as 3-bit constants), MuxSel constants (MUX_IDLE=0, MUX_START=1, MUX_DATA=2, MUX_PAR=3).
- One sub-module: parity_calc (combinational, DATA_WIDTH data + ParTyp → parity bit), shared with a future receiver.

Test Plan:
- Reset: hold TxCtrl_RST_ASYN low mid-DATA → all outputs at reset values immediately; DataReady=1, MuxSel=0.
- 8E1 frame: DataIn=0xD6, ParEn=1, ParTyp=0, Done after 8 DATA cycles → MuxSel 1,2×8,3,0; ParityBit=1; Busy for 11 cycles; SerData=0xD6 during START.
- Odd parity, no parity: 0xD6 with ParTyp=1 → ParityBit=0. Same byte with ParEn=0 → DATA→STOP, 10-cycle frame, MuxSel never 3.
- Back-to-back: accept 0xA5 during 0xD6 frame (Ready drops to 0 until START of next) → second START immediately after the STOP cycle, no IDLE cycle.
- Timeout: Ser_Done held low → FrameErr one pulse at DATA cycle 10, then STOP, then IDLE; next frame proceeds normally.
- Ready handshake: Valid held high with Ready=0 → byte not latched until Ready=1; exactly one acceptance per Ready window.
